dff_bank_arb: RTL and testbench

Round-robin write arbiter and sequencer for a shared WIDTH-bit register bank built from `dff2` cells. It accepts write requests from NREQ requesters and grants the bank to one owner at a time. Each grant is a bounded burst of writes, after which ownership passes on fairly. It sits between the requesting blocks and the storage, and is the only path by which the bank is written.

---
 rtl/dff_bank_arb_pkg.sv | 15 +
 rtl/dff_bank_arb_bank.sv | 53 +++++
 rtl/dff_bank_arb.sv | 112 +++++++++++
 tb/tb_dff_bank_arb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dff_bank_arb_pkg.sv
// Shared definitions for the dff_bank_arb write arbiter: FSM state encodings
// and default parameter values.
package dff_bank_arb_pkg;

    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_NREQ     = 4;
    localparam int unsigned DEF_MAX_HOLD = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/dff_bank_arb_bank.sv
// dff2 storage cell and the WIDTH-bit register bank built from it; dff2 has no
// enable, so each bit recirculates its own q through a hold mux on idle cycles.
module dff2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic qn
);

    logic q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= d;
        end
    end

    assign q  = q_q;
    assign qn = ~q_q;

endmodule

module dff_bank
    import dff_bank_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic d_hold;

        assign d_hold = we ? d[i] : q[i];

        dff2 u_cell (
            .clk (clk),
            .rst (rst),
            .d   (d_hold),
            .q   (q[i]),
            .qn  (qn[i])
        );
    end

endmodule

// File: rtl/dff_bank_arb.sv
// Round-robin write arbiter for a shared dff2 register bank: one owner at a
// time, bursts capped at MAX_HOLD writes, ownership rotates after each grant.
module dff_bank_arb
    import dff_bank_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned NREQ     = DEF_NREQ,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           last,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    output logic [NREQ-1:0]           gnt,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy,
    output logic [WIDTH-1:0]          bank_q,
    output logic [WIDTH-1:0]          bank_qn
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    state_e           state_q;
    logic [NREQ-1:0]  gnt_q;
    logic [PW-1:0]    owner_q;
    logic [PW-1:0]    ptr_q;
    logic [CW-1:0]    cnt_q;

    logic [PW-1:0]    sel_d;
    logic             found_d;
    logic [PW-1:0]    cand;
    logic [CW-1:0]    cnt_inc;
    logic             we;
    logic [WIDTH-1:0] wsel;

    // NREQ is a power of two, so PW-bit addition wraps the search naturally.
    always_comb begin
        sel_d   = '0;
        found_d = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = ptr_q + PW'(k);
            if (!found_d && req[cand]) begin
                sel_d   = cand;
                found_d = 1'b1;
            end
        end
    end

    assign we      = (state_q == ST_GRANT) && req[owner_q];
    assign cnt_inc = cnt_q + CW'(1);
    assign wsel    = wdata[owner_q*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found_d) begin
                        owner_q <= sel_d;
                        gnt_q   <= NREQ'(1) << sel_d;
                        cnt_q   <= '0;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (req[owner_q]) begin
                        cnt_q <= cnt_inc;
                        if (last[owner_q] || (cnt_inc == CW'(MAX_HOLD))) begin
                            gnt_q   <= '0;
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        gnt_q   <= '0;
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    ptr_q   <= owner_q + PW'(1);
                    state_q <= ST_IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = (state_q != ST_IDLE);

    dff_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .d   (wsel),
        .q   (bank_q),
        .qn  (bank_qn)
    );

endmodule

// File: tb/tb_dff_bank_arb.sv
// Directed bench for dff_bank_arb with hand-computed expectations per scenario.
module tb_dff_bank_arb;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREQ  = 4;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       last;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [1:0]            owner;
    logic                  busy;
    logic [WIDTH-1:0]      bank_q;
    logic [WIDTH-1:0]      bank_qn;

    int vecs;
    int errs;

    dff_bank_arb #(
        .WIDTH    (WIDTH),
        .NREQ     (NREQ),
        .MAX_HOLD (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .last    (last),
        .wdata   (wdata),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .bank_q  (bank_q),
        .bank_qn (bank_qn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; last = '0; wdata = '0;
        #2;
        vecs++; if (gnt !== 4'b0000) begin errs++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vecs++; if (owner !== 2'd0) begin errs++; $display("FAIL reset_owner got %0d want 0", owner); end
        vecs++; if (bank_q !== 8'h00) begin errs++; $display("FAIL reset_bank_q got %h want 00", bank_q); end
        vecs++; if (bank_qn !== 8'hFF) begin errs++; $display("FAIL reset_bank_qn got %h want ff", bank_qn); end
        #1 rst = 1'b0;
        tick();
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_round_robin;
        int exp_own [6] = '{0, 1, 3, 0, 1, 3};
        req  = 4'b1011;
        last = 4'b1011;
        for (int i = 0; i < 4; i++) wdata[i*WIDTH +: WIDTH] = 8'h50 + WIDTH'(i);
        for (int g = 0; g < 6; g++) begin
            tick();
            vecs++; if (gnt !== (4'b0001 << exp_own[g]) || owner !== 2'(exp_own[g])) begin
                errs++; $display("FAIL rr_grant[%0d] got gnt=%b owner=%0d want owner=%0d", g, gnt, owner, exp_own[g]);
            end
            tick();
            vecs++; if (bank_q !== 8'h50 + 8'(exp_own[g]) || gnt !== 4'b0000) begin
                errs++; $display("FAIL rr_write[%0d] got bank=%h gnt=%b want bank=%h gnt=0000", g, bank_q, gnt, 8'h50 + 8'(exp_own[g]));
            end
            tick();
            vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rr_idle[%0d] got busy=%b want 0", g, busy); end
        end
        req = '0; last = '0;
    endtask

    task automatic test_single_burst;
        req = 4'b0010; last = '0; wdata[1*WIDTH +: WIDTH] = 8'h11;
        tick();
        vecs++; if (gnt !== 4'b0010 || owner !== 2'd1 || busy !== 1'b1 || bank_q !== 8'h53) begin
            errs++; $display("FAIL single_grant got gnt=%b owner=%0d busy=%b bank=%h want 0010/1/1/53", gnt, owner, busy, bank_q);
        end
        tick();
        vecs++; if (bank_q !== 8'h11 || gnt !== 4'b0010) begin
            errs++; $display("FAIL single_w1 got bank=%h gnt=%b want 11/0010", bank_q, gnt);
        end
        wdata[1*WIDTH +: WIDTH] = 8'h22; last = 4'b0010;
        tick();
        vecs++; if (bank_q !== 8'h22 || gnt !== 4'b0000 || busy !== 1'b1) begin
            errs++; $display("FAIL single_w2 got bank=%h gnt=%b busy=%b want 22/0000/1", bank_q, gnt, busy);
        end
        req = '0; last = '0;
        tick();
        vecs++; if (busy !== 1'b0 || gnt !== 4'b0000 || owner !== 2'd1 || bank_q !== 8'h22) begin
            errs++; $display("FAIL single_release got busy=%b gnt=%b owner=%0d bank=%h want 0/0000/1/22", busy, gnt, owner, bank_q);
        end
    endtask

    task automatic test_max_hold;
        req = 4'b0100; last = '0; wdata[2*WIDTH +: WIDTH] = 8'h41;
        tick();
        vecs++; if (gnt !== 4'b0100 || owner !== 2'd2) begin
            errs++; $display("FAIL cap_grant got gnt=%b owner=%0d want 0100/2", gnt, owner);
        end
        for (int k = 1; k <= 4; k++) begin
            wdata[2*WIDTH +: WIDTH] = 8'h40 + 8'(k);
            tick();
            vecs++; if (bank_q !== 8'h40 + 8'(k) || gnt !== ((k == 4) ? 4'b0000 : 4'b0100)) begin
                errs++; $display("FAIL cap_write[%0d] got bank=%h gnt=%b want bank=%h", k, bank_q, gnt, 8'h40 + 8'(k));
            end
        end
        wdata[2*WIDTH +: WIDTH] = 8'h45;
        tick();
        vecs++; if (gnt !== 4'b0000 || busy !== 1'b0 || bank_q !== 8'h44) begin
            errs++; $display("FAIL cap_gap got gnt=%b busy=%b bank=%h want 0000/0/44", gnt, busy, bank_q);
        end
        wdata[2*WIDTH +: WIDTH] = 8'h46;
        tick();
        vecs++; if (gnt !== 4'b0100 || bank_q !== 8'h44) begin
            errs++; $display("FAIL cap_regrant got gnt=%b bank=%h want 0100/44", gnt, bank_q);
        end
        req = '0;
        tick();
        vecs++; if (gnt !== 4'b0000 || bank_q !== 8'h44) begin
            errs++; $display("FAIL cap_drop got gnt=%b bank=%h want 0000/44", gnt, bank_q);
        end
        tick();
    endtask

    task automatic test_abandon;
        req = 4'b1000; last = '0; wdata[3*WIDTH +: WIDTH] = 8'h3C;
        tick();
        vecs++; if (gnt !== 4'b1000 || owner !== 2'd3) begin
            errs++; $display("FAIL abandon_grant got gnt=%b owner=%0d want 1000/3", gnt, owner);
        end
        tick();
        vecs++; if (bank_q !== 8'h3C) begin errs++; $display("FAIL abandon_w1 got %h want 3c", bank_q); end
        req = '0; wdata[3*WIDTH +: WIDTH] = 8'hC3;
        tick();
        vecs++; if (bank_q !== 8'h3C || gnt !== 4'b0000) begin
            errs++; $display("FAIL abandon_drop got bank=%h gnt=%b want 3c/0000", bank_q, gnt);
        end
        tick();
        vecs++; if (bank_q !== 8'h3C || busy !== 1'b0) begin
            errs++; $display("FAIL abandon_idle got bank=%h busy=%b want 3c/0", bank_q, busy);
        end
        req = 4'b1001; last = 4'b1001; wdata[0 +: WIDTH] = 8'h77;
        tick();
        vecs++; if (gnt !== 4'b0001 || owner !== 2'd0) begin
            errs++; $display("FAIL abandon_next got gnt=%b owner=%0d want 0001/0", gnt, owner);
        end
        tick();
        vecs++; if (bank_q !== 8'h77) begin errs++; $display("FAIL abandon_next_w got %h want 77", bank_q); end
        req = '0; last = '0;
        tick();
    endtask

    task automatic test_hold;
        for (int c = 0; c < 10; c++) begin
            wdata = (c % 2 == 0) ? {NREQ{8'hFF}} : {NREQ{8'h00}};
            tick();
            vecs++; if (bank_q !== 8'h77 || bank_qn !== 8'h88 || gnt !== 4'b0000) begin
                errs++; $display("FAIL hold[%0d] got bank=%h qn=%h gnt=%b want 77/88/0000", c, bank_q, bank_qn, gnt);
            end
        end
    endtask

    task automatic test_reset_mid_burst;
        req = 4'b0100; last = '0; wdata[2*WIDTH +: WIDTH] = 8'hA5;
        tick();
        vecs++; if (gnt !== 4'b0100) begin errs++; $display("FAIL rstmid_grant got %b want 0100", gnt); end
        tick();
        vecs++; if (bank_q !== 8'hA5 || gnt !== 4'b0100) begin
            errs++; $display("FAIL rstmid_w got bank=%h gnt=%b want a5/0100", bank_q, gnt);
        end
        #2 rst = 1'b1;
        #1;
        vecs++; if (bank_q !== 8'h00 || bank_qn !== 8'hFF || gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
            errs++; $display("FAIL rstmid_async got bank=%h qn=%h gnt=%b busy=%b owner=%0d want 00/ff/0000/0/0", bank_q, bank_qn, gnt, busy, owner);
        end
        #2;
        rst = 1'b0; req = 4'b1001; last = '0;
        tick();
        vecs++; if (gnt !== 4'b0001 || owner !== 2'd0) begin
            errs++; $display("FAIL rstmid_ptr got gnt=%b owner=%0d want 0001/0", gnt, owner);
        end
        req = '0;
        tick();
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_round_robin();
        test_single_burst();
        test_max_hold();
        test_abandon();
        test_hold();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
